// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared key codes and key classification for the PS/2 key path
//
// Contents:
//   KEY_ESC, KEY_ENTER, KEY_SPACE, KEY_0, KEY_9 : special ASCII codes from the keyboard front end
//   is_sys_key(code)                            : 1 when the code belongs to the system/menu consumer
package ps2_key_pkg;

    localparam logic [7:0] KEY_ESC   = 8'h01;
    localparam logic [7:0] KEY_ENTER = 8'hFF;
    localparam logic [7:0] KEY_SPACE = 8'h20;
    localparam logic [7:0] KEY_0     = 8'h30;
    localparam logic [7:0] KEY_9     = 8'h39;

    typedef enum logic {
        KEY_CLASS_GAME = 1'b0,
        KEY_CLASS_SYS  = 1'b1
    } key_class_t;

    // System keys: ESC, ENTER, SPACE and the digits; everything else goes to the game.
    function automatic logic is_sys_key(input logic [7:0] code);
        logic sys;
        sys = (code == KEY_ESC) || (code == KEY_ENTER) || (code == KEY_SPACE) ||
              ((code >= KEY_0) && (code <= KEY_9));
        return sys;
    endfunction

    function automatic key_class_t classify_key(input logic [7:0] code);
        return is_sys_key(code) ? KEY_CLASS_SYS : KEY_CLASS_GAME;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - synchronous FIFO with push/pop/flush and occupancy count
//
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width)
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push, wdata       : write request and data; ignored when full unless popping in the same cycle
//   pop               : read request; ignored when empty
//   flush             : synchronous clear, wins over push/pop
//   rdata             : head entry (valid when !empty)
//   full, empty       : status flags
//   count             : occupied entries, 0..DEPTH
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic do_push;
    logic do_pop;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // At full, a simultaneous pop frees the head slot, which is exactly the slot being written.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observable between the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ps2_key_dispatcher.sv
// rtl/ps2_key_dispatcher.sv - buffers PS/2 key events and dispatches them in order to game or system consumers
//
// Optional feature macro: KEY_REPEAT_FILTER_EN (repeat filter with HOLDOFF_CYCLES holdoff window)
// Parameters: DEPTH (FIFO entries, power of 2, >= 2), HOLDOFF_CYCLES (repeat-filter window)
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   key_pressed, key_data  : one-cycle event strobe and ASCII code
//   flush                  : synchronous clear of FIFO, overflow and filter state
//   game_valid/data/ready  : head delivery to the game consumer (data 8'h00 when not valid)
//   sys_valid/data/ready   : head delivery to the system/menu consumer (data 8'h00 when not valid)
//   fifo_count             : occupied entries
//   overflow               : sticky, set when an event is dropped on a full FIFO
module ps2_key_dispatcher
    import ps2_key_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int HOLDOFF_CYCLES = 2500000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_pressed,
    input  logic [7:0]               key_data,
    input  logic                     flush,
    output logic                     game_valid,
    output logic [7:0]               game_data,
    input  logic                     game_ready,
    output logic                     sys_valid,
    output logic [7:0]               sys_data,
    input  logic                     sys_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    logic [7:0] head_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       repeat_block;
    logic       push_req;
    logic       fifo_pop;
    logic       push_accepted;
    key_class_t head_class;

    // Head classification; only one consumer sees the head, so a stalled head blocks both classes.
    assign head_class = classify_key(head_data);
    assign game_valid = !fifo_empty && (head_class == KEY_CLASS_GAME);
    assign sys_valid  = !fifo_empty && (head_class == KEY_CLASS_SYS);
    assign game_data  = game_valid ? head_data : 8'h00;
    assign sys_data   = sys_valid  ? head_data : 8'h00;

    assign fifo_pop      = ((game_valid && game_ready) || (sys_valid && sys_ready)) && !flush;
    assign push_req      = key_pressed && !repeat_block && !flush;
    assign push_accepted = push_req && (!fifo_full || fifo_pop);

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (key_data),
        .pop   (fifo_pop),
        .flush (flush),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic [HW-1:0] holdoff_cnt;
    logic [7:0]    last_key;

    // A filtered repeat is a deliberate discard, never an overflow.
    assign repeat_block = (key_data == last_key) && (holdoff_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdoff_cnt <= '0;
            last_key    <= 8'h00;
        end else if (flush) begin
            holdoff_cnt <= '0;
            last_key    <= 8'h00;
        end else if (push_accepted) begin
            holdoff_cnt <= HW'(HOLDOFF_CYCLES);
            last_key    <= key_data;
        end else if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - 1'b1;
        end
    end
`else
    logic unused_holdoff;

    assign repeat_block   = 1'b0;
    assign unused_holdoff = (HOLDOFF_CYCLES != 0) ^ push_accepted;
`endif

endmodule
